// File: rtl/prog_loader.sv
// Byte-stream program loader for cpu2: assembles little-endian words from a host
// link, writes them to IMEM/DMEM through one write port, and gates the CPU reset.
//
// state | meaning
// IDLE  | waiting for a command byte
// CNT0  | expecting word count, low byte
// CNT1  | expecting word count, high byte
// ADR0  | expecting start word address, low byte
// ADR1  | expecting start word address, high byte
// DATA  | collecting the 4 bytes of the current word
// WRITE | one-cycle memory write strobe, input stalled
// RUN   | CPU released from reset (terminal)
// ERR   | illegal command seen, bytes drained and discarded (terminal)
module prog_loader #(
  parameter int          AW       = 10,
  parameter logic [7:0]  CMD_IMEM = 8'hA5,
  parameter logic [7:0]  CMD_DMEM = 8'h5A,
  parameter logic [7:0]  CMD_RUN  = 8'hFF
) (
  input  logic          clk,
  input  logic          rst_,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          mem_we,
  output logic          mem_sel,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          cpu_rst_,
  output logic          busy,
  output logic          load_error
);

  typedef enum logic [3:0] {
    IDLE, CNT0, CNT1, ADR0, ADR1, DATA, WRITE, RUN, ERR
  } state_t;

  state_t        state_q, state_d;
  logic          sel_q, sel_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [1:0]    idx_q, idx_d;
  logic          we_q, we_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic          cpu_rst_q, cpu_rst_d;
  logic          accept;
  logic [15:0]   adr_full;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    idx_d     = idx_q;
    busy_d    = busy_q;
    err_d     = err_q;
    cpu_rst_d = cpu_rst_q;
    adr_full  = 16'h0000;
    in_ready  = !((state_q == WRITE) || (state_q == RUN));
    accept    = in_valid && in_ready;

    case (state_q)
      IDLE: if (accept) begin
        if ((in_data == CMD_IMEM) || (in_data == CMD_DMEM)) begin
          sel_d   = (in_data == CMD_DMEM);
          busy_d  = 1'b1;
          state_d = CNT0;
        end else if (in_data == CMD_RUN) begin
          cpu_rst_d = 1'b1;
          state_d   = RUN;
        end else begin
          err_d   = 1'b1;
          state_d = ERR;
        end
      end
      CNT0: if (accept) begin
        cnt_d[7:0] = in_data;
        state_d    = CNT1;
      end
      CNT1: if (accept) begin
        cnt_d[15:8] = in_data;
        state_d     = ADR0;
      end
      ADR0: if (accept) begin
        adr_full = {8'h00, in_data};
        addr_d   = adr_full[AW-1:0];
        state_d  = ADR1;
      end
      ADR1: if (accept) begin
        // Address bits above AW are dropped here.
        adr_full = {in_data, addr_q[7:0]};
        addr_d   = adr_full[AW-1:0];
        idx_d    = 2'd0;
        if (cnt_q == 16'd0) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = DATA;
        end
      end
      DATA: if (accept) begin
        wdata_d[{idx_q, 3'b000} +: 8] = in_data;
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = WRITE;
      end
      WRITE: begin
        cnt_d = cnt_q - 16'd1;
        if (cnt_q == 16'd1) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          addr_d  = addr_q + AW'(1);
          state_d = DATA;
        end
      end
      RUN: state_d = RUN;
      ERR: state_d = ERR;
      default: state_d = IDLE;
    endcase

    we_d = (state_d == WRITE);
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q   <= IDLE;
      sel_q     <= 1'b0;
      cnt_q     <= 16'h0000;
      addr_q    <= '0;
      wdata_q   <= 32'h0000_0000;
      idx_q     <= 2'd0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      cpu_rst_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      idx_q     <= idx_d;
      we_q      <= we_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      cpu_rst_q <= cpu_rst_d;
    end
  end

  assign mem_we     = we_q;
  assign mem_sel    = sel_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign cpu_rst_   = cpu_rst_q;
  assign busy       = busy_q;
  assign load_error = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes are queued by the stimulus,
// a negedge monitor pops and compares on every mem_we pulse.
module tb_prog_loader;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_ = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          mem_we;
  logic          mem_sel;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_rst_;
  logic          busy;
  logic          load_error;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic          sel;
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t exp_q[$];

  prog_loader #(.AW(AW)) dut (
    .clk(clk), .rst_(rst_), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_sel(mem_sel),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_rst_(cpu_rst_),
    .busy(busy), .load_error(load_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: write scoreboard plus the in_ready/mem_we relationship outside RUN.
  always @(negedge clk) begin
    if (rst_ && !cpu_rst_) chk("in_ready_vs_we", {31'd0, in_ready}, {31'd0, !mem_we});
    if (mem_we) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_write: got sel=%0d addr=%h data=%h expected none",
                 mem_sel, mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_sel",  {31'd0, mem_sel}, {31'd0, e.sel});
        chk("wr_addr", {22'd0, mem_addr}, {22'd0, e.addr});
        chk("wr_data", mem_wdata, e.data);
      end
    end
  end

  task automatic send(input logic [7:0] b, input int max_gap);
    int n;
    repeat ($urandom_range(max_gap, 0)) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 20 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int i = 0; i < 4; i++) send(w[8*i +: 8], max_gap);
  endtask

  task automatic push(input logic sel, input logic [AW-1:0] addr, input logic [31:0] data);
    wr_t e;
    e.sel = sel; e.addr = addr; e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_ = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_ = 1'b1;
    @(negedge clk);
  endtask

  task automatic drain_check(input string name);
    repeat (4) @(negedge clk);
    chk(name, exp_q.size(), 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 1);
    chk({tag, "_mem_we"},   {31'd0, mem_we}, 0);
    chk({tag, "_mem_sel"},  {31'd0, mem_sel}, 0);
    chk({tag, "_mem_addr"}, {22'd0, mem_addr}, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_cpu_rst_"}, {31'd0, cpu_rst_}, 0);
    chk({tag, "_busy"},     {31'd0, busy}, 0);
    chk({tag, "_load_error"}, {31'd0, load_error}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: IMEM load, 2 words
    do_reset();
    chk_reset_vals("rst");
    push(1'b0, 10'h000, 32'h0000_0013);
    push(1'b0, 10'h001, 32'h0010_0093);
    send(8'hA5, 0);
    chk("t1_busy_after_cmd", {31'd0, busy}, 1);
    send(8'h02, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
    send_word(32'h0000_0013, 0);
    send_word(32'h0010_0093, 0);
    drain_check("t1_writes_done");
    chk("t1_busy_end", {31'd0, busy}, 0);
    chk("t1_cpu_rst_", {31'd0, cpu_rst_}, 0);

    // 2: DMEM load with address wrap
    do_reset();
    push(1'b1, 10'h3FF, 32'hDEAD_BEEF);
    push(1'b1, 10'h000, 32'hCAFE_F00D);
    send(8'h5A, 0); send(8'h02, 0); send(8'h00, 0); send(8'hFF, 0); send(8'h03, 0);
    send_word(32'hDEAD_BEEF, 0);
    send_word(32'hCAFE_F00D, 0);
    drain_check("t2_writes_done");
    chk("t2_load_error", {31'd0, load_error}, 0);

    // 3: zero count, then run
    do_reset();
    send(8'hA5, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
    @(negedge clk);
    chk("t3_busy_zero", {31'd0, busy}, 0);
    chk("t3_cpu_rst_pre", {31'd0, cpu_rst_}, 0);
    send(8'hFF, 0);
    chk("t3_cpu_rst_post", {31'd0, cpu_rst_}, 1);
    @(negedge clk);
    chk("t3_in_ready", {31'd0, in_ready}, 0);
    chk("t3_busy_run", {31'd0, busy}, 0);
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = (i[0]) ? 8'hA5 : 8'h13;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("t3_in_ready_hold", {31'd0, in_ready}, 0);
    chk("t3_cpu_rst_hold", {31'd0, cpu_rst_}, 1);
    drain_check("t3_no_writes");

    // 4: illegal command
    do_reset();
    send(8'h3C, 0);
    chk("t4_load_error", {31'd0, load_error}, 1);
    send(8'hFF, 0);
    send(8'hA5, 0);
    @(negedge clk);
    chk("t4_load_error_sticky", {31'd0, load_error}, 1);
    chk("t4_cpu_rst_", {31'd0, cpu_rst_}, 0);
    chk("t4_in_ready", {31'd0, in_ready}, 1);
    drain_check("t4_no_writes");

    // 5: random gaps during a 3-word load; FF bytes inside the frame are data
    do_reset();
    push(1'b0, 10'h010, 32'h1122_3344);
    push(1'b0, 10'h011, 32'h5566_7788);
    push(1'b0, 10'h012, 32'hFF00_FFAA);
    send(8'hA5, 3); send(8'h03, 3); send(8'h00, 3); send(8'h10, 3); send(8'h00, 3);
    send_word(32'h1122_3344, 3);
    send_word(32'h5566_7788, 3);
    send_word(32'hFF00_FFAA, 3);
    drain_check("t5_writes_done");
    chk("t5_busy_end", {31'd0, busy}, 0);
    chk("t5_cpu_rst_", {31'd0, cpu_rst_}, 0);

    // 6: reset mid-frame, then a clean 1-word frame
    do_reset();
    send(8'h5A, 0); send(8'h01, 0); send(8'h00, 0); send(8'h05, 0); send(8'h00, 0);
    send(8'h01, 0); send(8'h02, 0);
    chk("t6_busy_mid", {31'd0, busy}, 1);
    @(negedge clk);
    rst_ = 1'b0;
    #1;
    chk_reset_vals("t6_rst");
    @(negedge clk);
    rst_ = 1'b1;
    @(negedge clk);
    push(1'b0, 10'h007, 32'hA1B2_C3D4);
    send(8'hA5, 0); send(8'h01, 0); send(8'h00, 0); send(8'h07, 0); send(8'h00, 0);
    send_word(32'hA1B2_C3D4, 0);
    drain_check("t6_writes_done");
    chk("t6_busy_end", {31'd0, busy}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Hardware program loader that replaces simulation-only memory preloading for cpu2.
- Accepts a byte stream over a valid/ready handshake and assembles 32-bit words from it.
- Writes the words into instruction memory or data memory through a single write port.
- Holds the CPU in reset until the host sends a release command.
- Sits between an external host link (UART/JTAG bridge) and the cpu2 memory write ports / cpu2 rst_.

Parameters:
- AW, 10, word-address width of each memory (1024 words).
- CMD_IMEM, 8'hA5, command byte: load instruction memory.
- CMD_DMEM, 8'h5A, command byte: load data memory.
- CMD_RUN, 8'hFF, command byte: release CPU from reset.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_  input  1  asynchronous active-low reset.
- in_valid  input  1  host byte valid.
- in_data  input  8  host byte.
- in_ready  output  1  loader can accept a byte; a byte transfers on a rising edge with in_valid && in_ready.
- mem_we  output  1  single-cycle write strobe.
- mem_sel  output  1  0 = instruction memory, 1 = data memory.
- mem_addr  output  AW  word address for the write.
- mem_wdata  output  32  write data.
- cpu_rst_  output  1  active-low reset to cpu2; low until CMD_RUN is accepted.
- busy  output  1  a load frame is in progress.
- load_error  output  1  sticky: an illegal command byte was received.

Behaviour:
- Reset values (asynchronous on rst_ low):
  - in_ready=1, mem_we=0, mem_sel=0, mem_addr=0, mem_wdata=0.
  - cpu_rst_=0, busy=0, load_error=0.
  - State = IDLE.
- Frame format, all multi-byte fields little-endian:
  - CMD, then CNT_L, CNT_H (16-bit word count N).
  - ADR_L, ADR_H (start word address; only the low AW bits are used).
  - Then N words of 4 bytes each, byte 0 first = bits [7:0].
- States: IDLE, CNT0, CNT1, ADR0, ADR1, DATA, WRITE, RUN, ERR.
- IDLE:
  - Accepted CMD_IMEM or CMD_DMEM: latch mem_sel, go to CNT0, busy=1.
  - Accepted CMD_RUN: go to RUN.
  - Any other byte: go to ERR.
- CNT0, CNT1, ADR0, ADR1: each accepts one byte, then advances to the next state.
- After ADR1:
  - N==0: return to IDLE, busy=0, no writes.
  - Otherwise go to DATA with byte index 0.
- DATA:
  - Shifts each accepted byte into the assembly register at lane = byte index.
  - After byte index 3 is accepted, go to WRITE.
- WRITE (exactly 1 cycle):
  - in_ready=0, mem_we=1; mem_addr and mem_wdata are held stable.
  - The remaining count decrements.
  - Remaining count now 0: go to IDLE, busy=0.
  - Otherwise go to DATA, and mem_addr increments on exit.
- Write latency: mem_we is asserted in the cycle after the 4th data byte is accepted.
- Maximum throughput: 1 word per 5 cycles.
- mem_addr increments modulo 2^AW; the wrap 2^AW-1 -> 0 is silent, not an error.
- mem_we, mem_sel, mem_addr and mem_wdata are registered outputs; mem_we is 0 outside WRITE.
- in_valid low in any state: the state holds and no partial byte is taken. Gaps between bytes of any length are legal.
- RUN (terminal):
  - cpu_rst_=1 from the cycle after CMD_RUN is accepted.
  - in_ready=0, busy=0, mem_we never asserted again.
  - Only rst_ leaves RUN.
- ERR (terminal):
  - load_error=1, in_ready=1 so the host can drain bytes, which are discarded.
  - cpu_rst_ stays 0; only rst_ leaves ERR.
- CMD_RUN is only recognised in IDLE. 8'hFF inside a frame is data.
- rst_ asserted mid-frame: all state clears immediately, including any pending write. A partially loaded memory keeps its contents, because the memory is not reset by this block.

Test Plan:
1. IMEM load, 2 words:
   - Stimulus: after reset, bytes A5 02 00 00 00 | 13 00 00 00 | 93 00 10 00.
   - Required: mem_we pulses twice, sel=0, (addr 0, 32'h00000013) then (addr 1, 32'h00100093); busy falls after the second write; cpu_rst_=0.
2. DMEM load with wrap:
   - Stimulus: 5A 02 00 FF 03 then words DEADBEEF, CAFEF00D.
   - Required: writes at addr 10'h3FF then 10'h000, sel=1, data 32'hDEADBEEF then 32'hCAFEF00D.
3. Zero count then run:
   - Stimulus: A5 00 00 00 00, then FF.
   - Required: no mem_we; cpu_rst_ rises 1 cycle after FF is accepted; in_ready=0 afterwards and further valid bytes are ignored.
4. Illegal command:
   - Stimulus: byte 3C in IDLE.
   - Required: load_error=1 and stays 1; a following FF does not release cpu_rst_; in_ready=1.
5. Backpressure and gaps:
   - Stimulus: in_valid toggled randomly during a 3-word load.
   - Required: identical writes to the gap-free case; in_ready=0 exactly in WRITE cycles; no byte is lost or duplicated.
6. Reset mid-frame:
   - Stimulus: assert rst_ after the 2nd data byte, release it, then send a full 1-word frame.
   - Required: all outputs return to their reset values immediately on rst_ low; the new frame writes correctly with no stale bytes.
